// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers: S-box table, Rcon, xtime, MixColumn.
package aes_pkg;

  localparam int unsigned NR = 10;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
    return SBOX_TAB[(255 - int'(a)) * 8 +: 8];
  endfunction

  // Round constant for key-schedule round r (1..10).
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the [02 03 01 01] circulant matrix; byte 0 in [31:24].
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward S-box for one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_lookup(a);

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
module aes_top
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic         done
);

  logic [127:0] state_q;
  logic [127:0] rkey_q;
  logic [3:0]   round_q;

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] rk_next;
  logic [127:0] round_out;
  logic [31:0]  sw;
  logic [31:0]  temp;
  logic [31:0]  w0n, w1n, w2n, w3n;

  // SubBytes and ShiftRows: byte (col c, row r) takes byte (col c+r mod 4, row r)
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.a(state_q[127 - 8*i -: 8]), .y(sb[127 - 8*i -: 8]));
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127 - 8*(4*c + r) -: 8] = sb[127 - 8*(4*((c + r) % 4) + r) -: 8];
    end
    assign mc[127 - 32*c -: 32] = mix_column(sr[127 - 32*c -: 32]);
  end

  // SubWord on the last key word; rotation is applied after substitution
  for (genvar j = 0; j < 4; j++) begin : g_subword
    aes_sbox u_sbox (.a(rkey_q[31 - 8*j -: 8]), .y(sw[31 - 8*j -: 8]));
  end

  // Next round key and round result
  always_comb begin
    temp      = {sw[23:0], sw[31:24]} ^ {rcon(round_q), 24'h000000};
    w0n       = rkey_q[127:96] ^ temp;
    w1n       = rkey_q[95:64] ^ w0n;
    w2n       = rkey_q[63:32] ^ w1n;
    w3n       = rkey_q[31:0] ^ w2n;
    rk_next   = {w0n, w1n, w2n, w3n};
    round_out = ((round_q == 4'(NR)) ? sr : mc) ^ rk_next;
  end

  // Control and datapath registers; reset aborts any running block
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= '0;
      rkey_q     <= '0;
      round_q    <= '0;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          state_q <= plaintext ^ key;
          rkey_q  <= key;
          round_q <= 4'd1;
          busy    <= 1'b1;
        end
      end else begin
        state_q <= round_out;
        rkey_q  <= rk_next;
        if (round_q == 4'(NR)) begin
          ciphertext <= round_out;
          done       <= 1'b1;
          busy       <= 1'b0;
          round_q    <= '0;
        end else begin
          round_q <= round_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_top.sv
// Directed self-checking bench for aes_top using known-answer vectors.
module tb_aes_top;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         busy;
  logic         done;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  int passed = 0;
  int total  = 0;

  aes_top dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges after an accept until done is seen; 0 means it never came
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Drive a one-edge start pulse with the given block and key
  task automatic launch(input logic [127:0] p, input logic [127:0] k);
    plaintext = p;
    key       = k;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int n;
    int done_cnt;
    int busy_cnt;
    int done_at;

    rst = 1'b1; start = 1'b0; plaintext = '0; key = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ct",   ciphertext, '0);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));

    // Known answer 1
    launch(PT1, K1);
    check("kat1_busy", 128'(busy), 128'(1));
    wait_done(n);
    check("kat1_latency", 128'(n), 128'(10));
    check("kat1_ct",      ciphertext, CT1);
    check("kat1_idle",    128'(busy), 128'(0));
    tick();
    check("kat1_done_pulse", 128'(done), 128'(0));
    check("kat1_hold",       ciphertext, CT1);

    // Known answer 2
    launch(PT2, K2);
    wait_done(n);
    check("kat2_latency", 128'(n), 128'(10));
    check("kat2_ct",      ciphertext, CT2);
    tick();

    // Input changes and a start at cycle 3 of a running block are ignored
    launch(PT1, K1);
    done_cnt = 0; busy_cnt = (busy === 1'b1) ? 1 : 0; done_at = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin
        start = 1'b1; plaintext = PT2; key = K2;
      end
      if (i == 4) start = 1'b0;
      tick();
      if (done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    check("ignore_ct",       ciphertext, CT1);
    check("ignore_done_cnt", 128'(done_cnt), 128'(1));
    check("ignore_done_at",  128'(done_at), 128'(10));
    check("ignore_busy_cnt", 128'(busy_cnt), 128'(10));

    // Reset at cycle 5 aborts with no done pulse
    launch(PT2, K2);
    for (int i = 1; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ct",   ciphertext, '0);
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 128'(done_cnt), 128'(0));
    launch(PT1, K1);
    wait_done(n);
    check("after_rst_latency", 128'(n), 128'(10));
    check("after_rst_ct",      ciphertext, CT1);

    // Back-to-back: start in the done cycle
    plaintext = PT2; key = K2; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_accept_busy", 128'(busy), 128'(1));
    check("b2b_accept_done", 128'(done), 128'(0));
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i < 10) check("b2b_hold", ciphertext, CT1);
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    check("b2b_latency", 128'(n), 128'(10));
    check("b2b_ct",      ciphertext, CT2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
